// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time controller.
// Contents:
//   state_t          - controller states, IDLE through LATE
//   LFSR_TAPS        - feedback mask for the 16-bit hold-off LFSR
//   DEF_*            - default parameter values for reaction_ctrl
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_RAND = 3'd1,
      TIMING    = 3'd2,
      DONE      = 3'd3,
      EARLY     = 3'd4,
      LATE      = 3'd5
   } state_t;

   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int          DEF_MIN_DELAY_MS = 1000;
   localparam int          DEF_RAND_BITS    = 11;
   localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;

endpackage

// File: rtl/reaction_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running on every clock edge.
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset, loads SEED
//   q   - current LFSR state
// A nonzero SEED keeps the register out of the all-zero lock-up state.
module lfsr16
   import reaction_pkg::*;
#(
   parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   logic [15:0] q_q;
   logic [15:0] q_d;

   always_comb begin
      q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-tester sequencer: random hold-off, go LED, timed response.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   tick_1ms   - one-cycle pulse per millisecond
//   start      - begin a trial (honoured in IDLE/DONE/EARLY/LATE)
//   stop       - user response (honoured in WAIT_RAND and TIMING)
//   time_late  - counter stage has reached its limit (TIMING only)
//   time_clr   - one-cycle registered clear to the counter, cycle after start
//   time_en    - counter enable, the ms tick gated to TIMING without stop
//   led_go     - stimulus LED, high in TIMING
//   early      - false start, held in EARLY
//   late       - timeout, held in LATE
//   done       - valid reaction time held in the counter, high in DONE
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter int          MIN_DELAY_MS = DEF_MIN_DELAY_MS,
   parameter int          RAND_BITS    = DEF_RAND_BITS,
   parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_1ms,
   input  logic start,
   input  logic stop,
   input  logic time_late,
   output logic time_clr,
   output logic time_en,
   output logic led_go,
   output logic early,
   output logic late,
   output logic done
);

   // Wide enough for the largest load, MIN_DELAY_MS + 2^RAND_BITS - 1.
   localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
   // All-zero mask when RAND_BITS is 0, so the hold-off is exactly MIN_DELAY_MS.
   localparam logic [15:0] RAND_MASK = 16'((1 << RAND_BITS) - 1);
   localparam logic [DW-1:0] CNT_ONE = DW'(1);

   state_t        state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          time_clr_q, time_clr_d;
   logic [15:0]   lfsr_q;
   logic [DW-1:0] load_val;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr_q)
   );

   assign load_val = DW'(MIN_DELAY_MS + 32'(lfsr_q & RAND_MASK));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      time_clr_d = 1'b0;
      case (state_q)
         IDLE, DONE, EARLY, LATE: begin
            if (start) begin
               state_d    = WAIT_RAND;
               cnt_d      = load_val;
               time_clr_d = 1'b1;
            end
         end
         WAIT_RAND: begin
            // A response during the hold-off is a false start, even on the
            // tick that would have ended the hold-off.
            if (stop) begin
               state_d = EARLY;
            end else if (tick_1ms) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = TIMING;
               end
            end
         end
         TIMING: begin
            if (stop) begin
               state_d = DONE;
            end else if (time_late) begin
               state_d = LATE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         time_clr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         time_clr_q <= time_clr_d;
      end
   end

   // Combinational gate so the stop cycle never adds a count.
   assign time_en  = (state_q == TIMING) & tick_1ms & ~stop;
   assign time_clr = time_clr_q;
   assign led_go   = (state_q == TIMING);
   assign done     = (state_q == DONE);
   assign early    = (state_q == EARLY);
   assign late     = (state_q == LATE);

endmodule

// File: tb/tb_reaction_ctrl.sv
module tb_reaction_ctrl;
   import reaction_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic tick;
   logic start0, stop0, late0;
   logic start1, stop1, late1;
   logic clr0, en0, led0, early0, lt0, done0;
   logic clr1, en1, led1, early1, lt1, done1;

   always #5 clk = ~clk;

   reaction_ctrl #(.MIN_DELAY_MS(4), .RAND_BITS(0), .LFSR_SEED(16'hACE1)) dut0 (
      .clk(clk), .rst(rst), .tick_1ms(tick), .start(start0), .stop(stop0),
      .time_late(late0), .time_clr(clr0), .time_en(en0), .led_go(led0),
      .early(early0), .late(lt0), .done(done0)
   );

   reaction_ctrl #(.MIN_DELAY_MS(4), .RAND_BITS(2), .LFSR_SEED(16'h0001)) dut1 (
      .clk(clk), .rst(rst), .tick_1ms(tick), .start(start1), .stop(stop1),
      .time_late(late1), .time_clr(clr1), .time_en(en1), .led_go(led1),
      .early(early1), .late(lt1), .done(done1)
   );

   // Reference LFSR for dut1: taps 16,14,13,11, shifting toward the MSB.
   logic [15:0] ref_lfsr;
   always @(posedge clk or posedge rst) begin
      if (rst) ref_lfsr <= 16'h0001;
      else     ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
   end

   int n_check = 0;
   int n_pass  = 0;
   int en0_cnt = 0;
   logic en0_pre, en1_pre;
   logic [15:0] lfsr_pre;
   logic [31:0] exp_q[$];

   typedef struct {
      logic t, s, p, l;
      logic en;
      logic [4:0] outs; // {time_clr, led_go, early, late, done}
   } vec_t;
   vec_t vt[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_check++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   // One clock cycle: drive inputs at negedge, sample the combinational
   // enable and the reference LFSR before the edge, return at posedge+1.
   task automatic cyc(input int sel, input logic t, input logic s, input logic p, input logic l);
      @(negedge clk);
      tick = t;
      if (sel == 0) begin
         start0 = s; stop0 = p; late0 = l;
         start1 = 1'b0; stop1 = 1'b0; late1 = 1'b0;
      end else begin
         start1 = s; stop1 = p; late1 = l;
         start0 = 1'b0; stop0 = 1'b0; late0 = 1'b0;
      end
      #1;
      en0_pre  = en0;
      en1_pre  = en1;
      lfsr_pre = ref_lfsr;
      if (en0) en0_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic t, s, p, l, en, input logic [4:0] outs);
      vec_t v;
      v.t = t; v.s = s; v.p = p; v.l = l; v.en = en; v.outs = outs;
      vt.push_back(v);
   endtask

   // Ticks spaced ten clocks apart on dut0.
   task automatic slow_tick(input logic p);
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, p, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; tick = 0;
      start0 = 0; stop0 = 0; late0 = 0;
      start1 = 0; stop1 = 0; late1 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs0", {clr0, en0, led0, early0, lt0, done0}, 6'b0);
      check("reset_outs1", {clr1, en1, led1, early1, lt1, done1}, 6'b0);
      check("reset_state0", 32'(dut0.state_q), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;

      // ---------------- table-driven sequence on dut0 ----------------
      add(0,0,0,0, 0, 5'b00000);
      add(0,1,0,0, 0, 5'b10000);  // start -> clr pulse
      add(0,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b00000);
      add(0,1,0,0, 0, 5'b00000);  // start ignored in WAIT_RAND
      add(1,0,0,0, 0, 5'b00000);
      add(0,0,0,1, 0, 5'b00000);  // time_late ignored in WAIT_RAND
      add(1,0,0,0, 0, 5'b01000);  // 4th tick -> TIMING
      add(1,0,0,0, 1, 5'b01000);
      add(0,1,0,0, 0, 5'b01000);  // start ignored in TIMING
      add(1,0,0,0, 1, 5'b01000);
      add(1,0,1,0, 0, 5'b00001);  // stop with tick: no enable, DONE
      add(1,0,1,1, 0, 5'b00001);  // stop/late ignored in DONE
      add(0,1,0,0, 0, 5'b10000);  // restart from DONE
      add(1,0,0,0, 0, 5'b00000);
      add(0,0,1,0, 0, 5'b00100);  // false start
      add(1,0,1,1, 0, 5'b00100);
      add(0,1,0,0, 0, 5'b10000);  // restart from EARLY
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b01000);
      add(0,0,0,1, 0, 5'b00010);  // timeout
      add(1,0,1,0, 0, 5'b00010);
      add(0,1,0,0, 0, 5'b10000);  // restart from LATE
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b01000);
      add(1,0,1,1, 0, 5'b00001);  // stop and late together -> DONE
      add(0,1,0,0, 0, 5'b10000);
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,0,0, 0, 5'b00000);
      add(1,0,1,0, 0, 5'b00100);  // stop beats terminal tick -> EARLY

      foreach (vt[i]) begin
         cyc(0, vt[i].t, vt[i].s, vt[i].p, vt[i].l);
         check($sformatf("vec%0d_en", i), en0_pre, vt[i].en);
         check($sformatf("vec%0d_outs", i), {clr0, led0, early0, lt0, done0}, vt[i].outs);
      end

      // ---------------- ticks every 10 clocks, 7-count trial ----------------
      cyc(0, 0, 1, 0, 0);
      check("slow_clr_hi", clr0, 1'b1);
      cyc(0, 0, 0, 0, 0);
      check("slow_clr_lo", clr0, 1'b0);
      en0_cnt = 0;
      for (int i = 0; i < 3; i++) slow_tick(1'b0);
      check("slow_led_before", led0, 1'b0);
      slow_tick(1'b0);
      check("slow_led_rise", led0, 1'b1);
      check("slow_no_en_wait", en0_cnt, 0);
      exp_q.push_back(32'd7);
      for (int i = 0; i < 7; i++) slow_tick(1'b0);
      slow_tick(1'b1);             // stop coincident with the 8th tick
      check("slow_en_count", en0_cnt, exp_q.pop_front());
      check("slow_done", {led0, done0}, 2'b01);

      // ---------------- reset mid-WAIT_RAND ----------------
      cyc(0, 0, 1, 0, 0);
      check("rst_w_clr_pre", clr0, 1'b1);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);           // ignored start keeps clr low
      cyc(0, 1, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("rst_w_outs", {clr0, en0, led0, early0, lt0, done0}, 6'b0);
      check("rst_w_state", 32'(dut0.state_q), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;

      // ---------------- reset mid-TIMING ----------------
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
      check("rst_t_pre_led", {led0, en0}, 2'b11);
      #2 rst = 1'b1;
      #1;
      check("rst_t_outs", {clr0, en0, led0, early0, lt0, done0}, 6'b0);
      check("rst_t_state", 32'(dut0.state_q), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0);
      check("rst_no_clr", clr0, 1'b0);

      // Normal trial after reset.
      cyc(0, 0, 1, 0, 0);
      check("post_rst_clr", clr0, 1'b1);
      en0_cnt = 0;
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
      check("post_rst_led", led0, 1'b1);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);           // start ignored
      cyc(0, 0, 0, 1, 0);
      check("post_rst_done", {done0, led0}, 2'b10);
      check("post_rst_en", en0_cnt, 2);

      // ---------------- random hold-off on dut1 ----------------
      for (int trial = 0; trial < 50; trial++) begin
         int ticks;
         int gap;
         logic [31:0] exp_hold;
         gap = $urandom_range(0, 5);
         for (int g = 0; g < gap; g++) cyc(1, 0, 0, 0, 0);
         cyc(1, 0, 1, 0, 0);
         exp_q.push_back(32'd4 + 32'(lfsr_pre[1:0]));
         ticks = 0;
         while (ticks < 20 && !led1) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cyc(1, 0, 0, 0, 0);
            cyc(1, 1, 0, 0, 0);
            ticks++;
         end
         exp_hold = exp_q.pop_front();
         check($sformatf("hold%0d_ticks", trial), ticks, exp_hold);
         check($sformatf("hold%0d_range", trial), 32'(ticks >= 4 && ticks <= 7), 32'd1);
         cyc(1, 0, 0, 1, 0);
         check($sformatf("hold%0d_done", trial), {done1, led1}, 2'b10);
      end

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
